cs_mult_arbiter: RTL

Round-robin arbiter and sequencer that shares one `multiCS4` 4×4 carry-save multiplier among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the winning operands, waits one cycle for the combinational multiplier to settle, then returns the product with the requester's ID over a single shared response channel. A wrapping completed-operation counter provides bring-up visibility.

---
 rtl/cs_mult_pkg.sv | 31 +++
 rtl/multiCS4.sv | 25 ++
 rtl/cs_mult_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/cs_mult_pkg.sv
// Shared types and helpers for the carry-save multiplier arbiter.
package cs_mult_pkg;
  localparam int OP_W    = 4;
  localparam int PROD_W  = 9;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of valid searching upward from ptr, wrapping at num.
  function automatic pick_t rr_pick(input logic [2:0] ptr,
                                    input logic [MAX_REQ-1:0] valid,
                                    input int num);
    pick_t res;
    int    j;
    res = '0;
    // Walk downward so the lowest offset overwrites last and wins.
    for (int k = MAX_REQ-1; k >= 0; k--) begin
      j = (int'(ptr) + k) % num;
      if (k < num && valid[j]) begin
        res.found = 1'b1;
        res.idx   = 3'(j);
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/multiCS4.sv
// 4x4 unsigned carry-save array multiplier, purely combinational.
module multiCS4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [8:0] p
);
  logic [8:0] s, c, row, s_n, c_n;

  always_comb begin
    s   = {5'b0, a & {4{b[0]}}};
    c   = '0;
    row = '0;
    s_n = '0;
    c_n = '0;
    // Each partial-product row is folded in with a 3:2 compressor.
    for (int i = 1; i < 4; i++) begin
      row = 9'(a & {4{b[i]}}) << i;
      s_n = s ^ c ^ row;
      c_n = ((s & c) | (s & row) | (c & row)) << 1;
      s   = s_n;
      c   = c_n;
    end
    p = s + c;
  end
endmodule

// File: rtl/cs_mult_arbiter.sv
// Round-robin arbiter sharing one multiCS4 among NUM_REQ requesters.
module cs_mult_arbiter
  import cs_mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_a,
  input  logic [4*NUM_REQ-1:0]    req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8:0]              rsp_product,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        op_count
);
  state_t                        state, state_nxt;
  logic [ID_W-1:0]               rr_ptr, id_q, gnt_id, ptr_nxt;
  logic [OP_W-1:0]               a_q, b_q;
  logic [PROD_W-1:0]             prod_q, mult_p;
  logic [NUM_REQ-1:0][OP_W-1:0]  a_arr, b_arr;
  logic [MAX_REQ-1:0]            vld_ext;
  pick_t                         pick;
  logic                          grant;

  assign a_arr = req_a;
  assign b_arr = req_b;

  always_comb begin
    vld_ext = '0;
    vld_ext[NUM_REQ-1:0] = req_valid;
  end

  assign pick    = rr_pick(3'(rr_ptr), vld_ext, NUM_REQ);
  assign gnt_id  = ID_W'(pick.idx);
  assign grant   = (state == IDLE) && pick.found;
  assign ptr_nxt = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;

  multiCS4 u_mult (.a(a_q), .b(b_q), .p(mult_p));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: if (pick.found) begin
        req_ready[gnt_id] = 1'b1;
        state_nxt         = CALC;
      end
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      prod_q   <= '0;
      op_count <= '0;
    end else begin
      if (grant) begin
        a_q    <= a_arr[gnt_id];
        b_q    <= b_arr[gnt_id];
        id_q   <= gnt_id;
        rr_ptr <= ptr_nxt;
      end
      // Multiplier has had a full cycle to settle from a_q/b_q.
      if (state == CALC) prod_q <= mult_p;
      if (state == RESP && rsp_ready) op_count <= op_count + 1'b1;
    end
  end

  assign rsp_valid   = (state == RESP);
  assign busy        = (state != IDLE);
  assign rsp_product = prod_q;
  assign rsp_id      = id_q;
endmodule
